sha256_core: RTL and testbench



---
 rtl/sha256_pkg.sv | 70 +++++++
 rtl/sha256_w_schedule.sv | 31 +++
 rtl/sha256_core.sv | 100 ++++++++++
 tb/tb_sha256_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, word type, FSM state enum and FIPS 180-4 round helper functions.
package sha256_pkg;

  localparam int ROUNDS  = 64;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int STATE_W = 256;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } core_state_e;

  localparam logic [STATE_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:ROUNDS-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_w_schedule.sv
// 16-word message schedule window: loads a block, then each advance shifts in W[t+16].
module sha256_w_schedule
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [BLOCK_W-1:0] block,
  output word_t              w_cur
);

  word_t win [0:15];
  word_t w_next;

  // The window holds W[t..t+15]; the next word is W[t+16].
  assign w_next = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
  assign w_cur  = win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[BLOCK_W-1-WORD_W*i -: WORD_W];
    end else if (advance) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
    end
  end

endmodule

// File: rtl/sha256_core.sv
// Iterative single-block SHA-256 compression, one round per clock.
// Define SHA256_CORE_BUSY_EN to add a busy output (high in ROUND and FINAL).
module sha256_core
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] start_state,
  input  logic [BLOCK_W-1:0] input_message,
  output logic [STATE_W-1:0] result,
  output logic               done
`ifdef SHA256_CORE_BUSY_EN
  ,
  output logic               busy
`endif
);

  core_state_e state;
  logic [5:0]  round_idx;
  word_t       h_reg [0:7];
  word_t       wk    [0:7];
  word_t       w_cur;
  word_t       t1;
  word_t       t2;
  logic        accept;

  // Start is honoured only when no computation is in flight.
  assign accept = start && (state == IDLE || state == DONE);

  sha256_w_schedule u_w_schedule (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance (state == ROUND),
    .block   (input_message),
    .w_cur   (w_cur)
  );

  always_comb begin
    t1 = wk[7] + big_sigma1(wk[4]) + ch(wk[4], wk[5], wk[6]) + K[round_idx] + w_cur;
    t2 = big_sigma0(wk[0]) + maj(wk[0], wk[1], wk[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      result    <= '0;
      round_idx <= '0;
`ifdef SHA256_CORE_BUSY_EN
      busy      <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        h_reg[i] <= '0;
        wk[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              h_reg[i] <= start_state[STATE_W-1-WORD_W*i -: WORD_W];
              wk[i]    <= start_state[STATE_W-1-WORD_W*i -: WORD_W];
            end
            round_idx <= '0;
            done      <= 1'b0;
`ifdef SHA256_CORE_BUSY_EN
            busy      <= 1'b1;
`endif
            state     <= ROUND;
          end
        end
        ROUND: begin
          wk[0] <= t1 + t2;
          wk[1] <= wk[0];
          wk[2] <= wk[1];
          wk[3] <= wk[2];
          wk[4] <= wk[3] + t1;
          wk[5] <= wk[4];
          wk[6] <= wk[5];
          wk[7] <= wk[6];
          round_idx <= round_idx + 6'd1;
          if (round_idx == 6'd63) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++)
            result[STATE_W-1-WORD_W*i -: WORD_W] <= h_reg[i] + wk[i];
          done  <= 1'b1;
`ifdef SHA256_CORE_BUSY_EN
          busy  <= 1'b0;
`endif
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core: known digests, chaining, disturbance, abort and restart.
module tb_sha256_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] start_state;
  logic [511:0] input_message;
  logic [255:0] result;
  logic         done;
`ifdef SHA256_CORE_BUSY_EN
  logic         busy;
`endif

  localparam logic [255:0] IV_VAL = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] MSG_EMPTY = {1'b1, 511'b0};
  localparam logic [511:0] MSG_ABC   = {24'h616263, 8'h80, 472'h0, 8'h18};
  localparam logic [511:0] MSG_L1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MSG_L2 = {448'h0, 64'h1c0};
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_LONG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  always #5 clk = ~clk;

  sha256_core dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_state   (start_state),
    .input_message (input_message),
    .result        (result),
    .done          (done)
`ifdef SHA256_CORE_BUSY_EN
    ,
    .busy          (busy)
`endif
  );

  logic [255:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    start_state   = {8{$urandom}};
    input_message = {16{$urandom}};
  endtask

  // Drives one accepted start; the expected digest enters the queue at the accepting edge.
  task automatic start_block(input logic [255:0] sv, input logic [511:0] msg,
                             input bit expect_valid, input logic [255:0] exp_dig);
    @(negedge clk);
    start         = 1'b1;
    start_state   = sv;
    input_message = msg;
    @(posedge clk);
    #1;
    if (expect_valid) exp_q.push_back(exp_dig);
    check("done_low_after_accept", {255'b0, done}, 256'd0);
    start = 1'b0;
    scramble_inputs();
  endtask

  // Waits for done with a bounded budget; optionally hammers start and inputs while rounds run.
  task automatic wait_result(input string tag, input bit disturb, input bit do_cmp);
    int cnt = 0;
    logic [255:0] exp_dig;
    while (cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) break;
`ifdef SHA256_CORE_BUSY_EN
      if (cnt == 10) check({tag, "_busy_mid"}, {255'b0, busy}, 256'd1);
`endif
      if (disturb && cnt < 55) begin
        start = 1'($urandom_range(0, 1));
        scramble_inputs();
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 256'(cnt), 256'd65);
`ifdef SHA256_CORE_BUSY_EN
    check({tag, "_busy_at_done"}, {255'b0, busy}, 256'd0);
`endif
    if (do_cmp) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 256'd1, 256'd0);
      end else begin
        exp_dig = exp_q.pop_front();
        check({tag, "_digest"}, result, exp_dig);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, {255'b0, done}, 256'd1);
        check({tag, "_digest_hold"}, result, exp_dig);
      end
    end
  endtask

  logic [255:0] mid_state;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_state = '0;
    input_message = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_done", {255'b0, done}, 256'd0);
    check("reset_result", result, 256'd0);

    start_block(IV_VAL, MSG_EMPTY, 1'b1, DIG_EMPTY);
    wait_result("empty", 1'b0, 1'b1);

    start_block(IV_VAL, MSG_ABC, 1'b1, DIG_ABC);
    wait_result("abc", 1'b0, 1'b1);

    // Restart straight from DONE; done must drop on the accepting edge.
    start_block(IV_VAL, MSG_ABC, 1'b1, DIG_ABC);
    wait_result("abc_b2b", 1'b0, 1'b1);

    start_block(IV_VAL, MSG_ABC, 1'b1, DIG_ABC);
    wait_result("abc_disturbed", 1'b1, 1'b1);

    start_block(IV_VAL, MSG_L1, 1'b0, 256'd0);
    wait_result("long_b1", 1'b0, 1'b0);
    mid_state = result;
    start_block(mid_state, MSG_L2, 1'b1, DIG_LONG);
    wait_result("long_b2", 1'b0, 1'b1);

    // Abort mid-computation: no result may follow.
    start_block(IV_VAL, MSG_EMPTY, 1'b0, 256'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_done", {255'b0, done}, 256'd0);
    check("abort_result", result, 256'd0);
    repeat (70) @(posedge clk);
    #1;
    check("abort_no_late_done", {255'b0, done}, 256'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    start_state = IV_VAL;
    input_message = MSG_ABC;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("rst_over_start_done", {255'b0, done}, 256'd0);

    start_block(IV_VAL, MSG_EMPTY, 1'b1, DIG_EMPTY);
    wait_result("empty_after_abort", 1'b0, 1'b1);

    check("queue_drained", 256'(exp_q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
